logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the team's two-input gate block.
- Takes WIDTH-bit operands A and B plus an opcode, and computes one bitwise logic function per transaction.
- Returns the result with zero, parity and popcount flags through valid/ready handshakes on both sides.
- Sits between a producer (register file / test driver) and a consumer that may apply backpressure.

Parameters:
WIDTH, 8, operand and result width in bits (1..64)
CNT_W, $clog2(WIDTH+1), popcount width (derived; not overridden)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer presents a transaction
in_ready  output  1  block can accept a transaction this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  3  opcode (see Behaviour)
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result this cycle
out_data  output  WIDTH  result
out_zero  output  1  out_data == 0
out_parity  output  1  XOR-reduction of out_data
out_popcnt  output  CNT_W  number of 1 bits in out_data

Behaviour:
- Clock and reset:
  - One clock domain (clk).
  - rst_n is asynchronous assert, synchronous deassert (externally synchronised), active-low.
  - In reset: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_zero=0, out_parity=0, out_popcnt=0, in_ready=1 on the first cycle after release.
- Opcodes (bitwise over WIDTH):
  - 0 AND: A&B
  - 1 OR: A|B
  - 2 NOTA: ~A
  - 3 NAND: ~(A&B)
  - 4 NOR: ~(A|B)
  - 5 XOR: A^B
  - 6 XNOR: ~(A^B)
  - 7 PASSB: B
  - All 8 codes are legal; there is no error path.
- Handshake:
  - A transfer occurs when valid && ready are both high on a rising edge.
  - in_valid, in_a, in_b and in_op are sampled only on a transfer.
  - out_data and the flags stay stable while out_valid=1 && out_ready=0.
- Pipeline (2 stages):
  - Stage 1 registers A, B and op.
  - Stage 2 computes the function and flags combinationally from stage 1, then registers them.
  - s2_free = !s2_valid || out_ready.
  - Stage 1 advances into stage 2 when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. This is a combinational path from out_ready; accepted.
  - out_valid = s2_valid.
- Latency and throughput:
  - Latency is 2 cycles: a transaction accepted at edge N has out_valid=1 after edge N+2 with no stall.
  - Throughput is 1 transaction/cycle while out_ready=1.
- Stall:
  - With out_ready held low, the block holds at most 2 transactions and then drops in_ready.
  - No transaction is lost or duplicated.
  - Order is strictly FIFO.
- Simultaneous events:
  - Output pop and input push in the same cycle on a full pipeline both succeed: everything shifts and the new input lands in stage 1.
- Flags:
  - Computed from the result, not the operands.
  - popcount ranges 0..WIDTH. For WIDTH=1, CNT_W=1.
- Reset mid-operation: all in-flight transactions are discarded and outputs return to the reset values immediately (asynchronous).

Decomposition:
- Package logic_unit_pkg holds:
  - The opcode enum: OP_AND=0, OP_OR, OP_NOTA, OP_NAND, OP_NOR, OP_XOR, OP_XNOR, OP_PASSB.
  - OP_W=3.
- Sub-module logic_unit_core: purely combinational, parametrised on WIDTH. Takes (a, b, op) and returns (data, zero, parity, popcnt). It is instantiated once, between stage 1 and stage 2.

Test Plan:
- Reset, then all opcodes with WIDTH=8, A=8'hA5, B=8'h0F, out_ready=1. Required out_data/popcnt per opcode:
  - AND 05/2
  - OR AF/6
  - NOTA 5A/4
  - NAND FA/6
  - NOR 50/2
  - XOR AA/4
  - XNOR 55/4
  - PASSB 0F/4
  - Each result appears exactly 2 cycles after its accept.
- Zero/parity: AND with A=8'hF0, B=8'h0F -> out_data=00, zero=1, parity=0, popcnt=0. XOR with A=8'h01, B=8'h00 -> parity=1, popcnt=1.
- Backpressure: hold out_ready=0 and drive 3 back-to-back transactions.
  - The first two are accepted; in_ready=0 in the 3rd cycle.
  - Raise out_ready: results drain in order and the 3rd transaction is accepted in the same cycle as the first pop.
- Streaming: 16 random transactions with in_valid=1 and out_ready=1 continuously -> one result per cycle, matching a reference model, in order.
- Random stalls: in_valid and out_ready each randomly toggled (50%) over 500 transactions -> scoreboard match; outputs stable whenever out_valid && !out_ready.
- Reset mid-flight: assert rst_n=0 with 2 transactions in the pipe -> out_valid=0 and all outputs 0 immediately. After release, no stale result appears and in_ready=1.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions for the pipelined bitwise logic unit.
// No logic; types and constants only.
// Imported by logic_unit_core and logic_unit_pipe.
package logic_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NOTA  = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XOR   = 3'd5,
        OP_XNOR  = 3'd6,
        OP_PASSB = 3'd7
    } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// Bitwise logic function of two operands plus result flags (zero, parity, popcount).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the enclosing pipeline decides when the result is captured.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] data,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] popcnt
);

    // Select the bitwise function; every opcode value is a legal operation.
    always_comb begin
        data = '0;
        case (op)
            OP_AND:   data = a & b;
            OP_OR:    data = a | b;
            OP_NOTA:  data = ~a;
            OP_NAND:  data = ~(a & b);
            OP_NOR:   data = ~(a | b);
            OP_XOR:   data = a ^ b;
            OP_XNOR:  data = ~(a ^ b);
            OP_PASSB: data = b;
        endcase
    end

    // Flags describe the result, never the operands.
    always_comb begin
        zero   = (data == '0);
        parity = ^data;
        popcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            popcnt = popcnt + CNT_W'(data[i]);
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with zero/parity/popcount flags.
// Latency: presented in cycle N, result valid in cycle N+2; 1 txn/cycle sustained.
// Backpressure: holds up to 2 txns under out_ready=0; in_ready follows out_ready combinationally.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_popcnt
);

    // Stage 1: registered operands and opcode.
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    op_e              s1_op_q, s1_op_d;

    // Stage 2: registered result and flags, driving the outputs directly.
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_parity_q, s2_parity_d;
    logic [CNT_W-1:0] s2_popcnt_q, s2_popcnt_d;

    // Combinational result of the stage-1 contents.
    logic [WIDTH-1:0] core_data;
    logic             core_zero;
    logic             core_parity;
    logic [CNT_W-1:0] core_popcnt;

    logic s2_free;
    logic s1_adv;
    logic in_fire;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .op     (s1_op_q),
        .data   (core_data),
        .zero   (core_zero),
        .parity (core_parity),
        .popcnt (core_popcnt)
    );

    // Handshake: stage 2 frees up when empty or popped this cycle, and stage 1
    // can take a new transaction whenever its occupant is moving on.
    always_comb begin
        s2_free  = !s2_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_free;
        in_ready = !s1_valid_q || s2_free;
        in_fire  = in_valid && in_ready;
    end

    // Next-state for both stages; data registers only load on a transfer so
    // the outputs hold steady while the consumer stalls.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        s2_valid_d  = s2_valid_q;
        s2_data_d   = s2_data_q;
        s2_zero_d   = s2_zero_q;
        s2_parity_d = s2_parity_q;
        s2_popcnt_d = s2_popcnt_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_op_d    = op_e'(in_op);
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            s2_valid_d  = 1'b1;
            s2_data_d   = core_data;
            s2_zero_d   = core_zero;
            s2_parity_d = core_parity;
            s2_popcnt_d = core_popcnt;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // Pipeline registers; reset discards any in-flight transactions at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= OP_AND;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_zero_q   <= 1'b0;
            s2_parity_q <= 1'b0;
            s2_popcnt_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_zero_q   <= s2_zero_d;
            s2_parity_q <= s2_parity_d;
            s2_popcnt_q <= s2_popcnt_d;
        end
    end

    // Outputs come straight from stage 2.
    always_comb begin
        out_valid  = s2_valid_q;
        out_data   = s2_data_q;
        out_zero   = s2_zero_q;
        out_parity = s2_parity_q;
        out_popcnt = s2_popcnt_q;
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: expected results queued at input transfer,
// checked by a monitor at each output transfer; randomized traffic against a model.
module tb_logic_unit_pipe;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [2:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_zero;
    logic          out_parity;
    logic [CW-1:0] out_popcnt;

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .out_parity (out_parity),
        .out_popcnt (out_popcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  data;
        logic          zero;
        logic          parity;
        logic [CW-1:0] popcnt;
        int            cyc;
        bit            lat;
    } exp_t;

    typedef struct {
        logic [W-1:0]  data;
        logic [CW-1:0] popcnt;
    } tbl_t;

    exp_t exp_q[$];
    tbl_t tbl_q[$];

    int   tests;
    int   fails;
    int   cyc;
    bit   lat_chk;
    bit   rdy_rand;

    // Held output values for the stall-stability check.
    bit            stall_prev;
    logic [W-1:0]  h_data;
    logic          h_zero;
    logic          h_parity;
    logic [CW-1:0] h_popcnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: the opcode table applied to whole words.
    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return a ^ b;
            3'd6:    return ~(a ^ b);
            default: return b;
        endcase
    endfunction

    always @(posedge clk) cyc++;

    // Random consumer backpressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard push on input transfer, pop/compare on output transfer,
    // plus stability of held outputs under stall.
    always @(negedge clk) begin
        exp_t e;
        tbl_t t;
        logic [W-1:0] r;
        if (rst_n) begin
            if (in_valid && in_ready) begin
                r        = model(in_op, in_a, in_b);
                e.data   = r;
                e.zero   = (r == '0);
                e.parity = ^r;
                e.popcnt = CW'($countones(r));
                e.cyc    = cyc;
                e.lat    = lat_chk;
                exp_q.push_back(e);
            end
            if (stall_prev) begin
                chk("hold_valid",  64'(out_valid),  64'd1);
                chk("hold_data",   64'(out_data),   64'(h_data));
                chk("hold_flags",  {61'd0, out_zero, out_parity, 1'b0} | 64'(out_popcnt) << 8,
                                   {61'd0, h_zero, h_parity, 1'b0} | 64'(h_popcnt) << 8);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data",   64'(out_data),   64'(e.data));
                    chk("zero",   64'(out_zero),   64'(e.zero));
                    chk("parity", 64'(out_parity), 64'(e.parity));
                    chk("popcnt", 64'(out_popcnt), 64'(e.popcnt));
                    if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
                end
                if (tbl_q.size() > 0) begin
                    t = tbl_q.pop_front();
                    chk("tbl_data",   64'(out_data),   64'(t.data));
                    chk("tbl_popcnt", 64'(out_popcnt), 64'(t.popcnt));
                end
            end
            stall_prev = out_valid && !out_ready;
            h_data     = out_data;
            h_zero     = out_zero;
            h_parity   = out_parity;
            h_popcnt   = out_popcnt;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Present one transaction (caller sits just after a rising edge) and hold it until taken.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit taken;
        taken    = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    logic [W-1:0]  tdat [8];
    logic [CW-1:0] tpop [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl_t t;
        tdat = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h0F};
        tpop = '{4'd2,  4'd6,  4'd4,  4'd6,  4'd2,  4'd4,  4'd4,  4'd4};
        tests = 0; fails = 0; cyc = 0;
        lat_chk = 1'b0; rdy_rand = 1'b0; stall_prev = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;

        // Reset state.
        #1;
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_out_data",   64'(out_data),   64'd0);
        chk("rst_out_zero",   64'(out_zero),   64'd0);
        chk("rst_out_parity", 64'(out_parity), 64'd0);
        chk("rst_out_popcnt", 64'(out_popcnt), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready",  64'(in_ready),  64'd1);
        chk("rel_out_valid", 64'(out_valid), 64'd0);

        // All opcodes back to back with A=A5, B=0F.
        @(posedge clk); #1;
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            t.data   = tdat[i];
            t.popcnt = tpop[i];
            tbl_q.push_back(t);
            send(3'(i), 8'hA5, 8'h0F);
        end
        wait_drain();

        // Zero and parity corners.
        t.data = 8'h00; t.popcnt = 4'd0; tbl_q.push_back(t);
        send(3'd0, 8'hF0, 8'h0F);
        t.data = 8'h01; t.popcnt = 4'd1; tbl_q.push_back(t);
        send(3'd5, 8'h01, 8'h00);
        @(negedge clk);
        chk("zero_flag", 64'(out_zero), 64'd1);
        chk("zero_par",  64'(out_parity), 64'd0);
        @(negedge clk);
        chk("xor_par",   64'(out_parity), 64'd1);
        chk("xor_zero",  64'(out_zero), 64'd0);
        wait_drain();
        lat_chk = 1'b0;

        // Backpressure: three back-to-back with consumer stalled.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_op = 3'($urandom_range(0, 7));
            in_a  = W'($urandom);
            in_b  = W'($urandom);
            @(negedge clk);
            chk($sformatf("bp_in_ready_%0d", i), 64'(in_ready), (i < 2) ? 64'd1 : 64'd0);
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_still_full", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_accept", 64'(in_ready),  64'd1);
        chk("bp_pop_valid",  64'(out_valid), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain();

        // Streaming: 16 random back to back, one result per cycle.
        lat_chk = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        end
        wait_drain();
        lat_chk = 1'b0;

        // Random stalls on both sides.
        rdy_rand = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk); #1;
            end
            send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        end
        wait_drain();
        rdy_rand = 1'b0;

        // Reset with two transactions in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(3'd1, 8'h3C, 8'h81);
        send(3'd5, 8'hFF, 8'h12);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",  64'(out_valid),  64'd0);
        chk("mid_rst_data",   64'(out_data),   64'd0);
        chk("mid_rst_flags",  {62'd0, out_zero, out_parity}, 64'd0);
        chk("mid_rst_popcnt", 64'(out_popcnt), 64'd0);
        exp_q.delete();
        tbl_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("post_rst_no_stale", 64'(out_valid), 64'd0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
